floating_point_divider: RTL and testbench
=========================================

FLOATING_POINT_DIVIDER -- requirements
Module: floating_point_divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the operand/result width; only 16 (IEEE-754 binary16) is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: start strobe; sampled only in IDLE.
REQ-005 SHALL have port a, input, DATA_WIDTH: the dividend, in binary16 format.
REQ-006 SHALL have port b, input, DATA_WIDTH: the divisor, in binary16 format.
REQ-007 SHALL have port result, output, DATA_WIDTH: the quotient a/b, registered.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle pulse, high when result is new.
REQ-009 SHALL have port busy, output, 1 bit: high while a division is in flight.

Function
REQ-010 SHALL implement the FSM states IDLE, DIVIDE, ROUND and DONE.
REQ-011 IDLE with en=1 at edge E0: SHALL capture a and b, unpack sign, exponent and 1.mantissa, set busy=1 and go to DIVIDE.
REQ-012 DIVIDE SHALL run a restoring mantissa division for exactly 14 cycles (E1..E14), producing one quotient bit per cycle, MSB first, via a 4-bit counter; at E14 it SHALL go to ROUND.
REQ-013 ROUND: quotient q[13:0] with q[13] as the integer bit; if q[13]=0, SHALL shift left 1 and decrement the exponent.
REQ-014 ROUND: SHALL take the exponent as ea-eb+15, held in a 7-bit signed intermediate.
REQ-015 ROUND: SHALL round to nearest-even using the guard bit and sticky = (remaining quotient bits | remainder≠0); a mantissa carry-out SHALL increment the exponent.
REQ-016 At E15 SHALL register result and enter DONE; valid=1 for exactly that cycle; fixed latency is 15 edges from the en sample for all operands.
REQ-017 DONE SHALL return to IDLE at the next edge with busy=0; en is accepted again from IDLE only.
REQ-018 en while busy or in DONE SHALL be ignored (no queueing); a and b may change freely after E0.
REQ-019 Sign SHALL be sa XOR sb for every result, including zero and infinity.
REQ-020 Subnormal inputs (exp=0) SHALL be treated as zero; a final exponent ≤0 SHALL yield signed zero (flush-to-zero); a final exponent ≥31 SHALL yield signed infinity.
REQ-021 Special cases SHALL follow the same 15-cycle timing: NaN operand, 0/0, or inf/inf -> canonical NaN 16'h7E00; finite/0 -> ±inf; inf/finite -> ±inf; finite/inf -> ±0; 0/finite -> ±0.
REQ-022 result SHALL hold its value between valid pulses.

Reset
REQ-023 reset=1 SHALL immediately force state=IDLE, result=16'h0000, valid=0, busy=0, and clear the counter and datapath registers.
REQ-024 Reset asserted mid-division SHALL abort the operation with no valid pulse; the first en after release SHALL start a clean division.

Structure
REQ-025 Shared package fp16_pkg SHALL hold EXP_W=5, MAN_W=10, BIAS=15, QNAN=16'h7E00, PINF=16'h7C00 and the FSM state enum; the existing floating_point_multiplayer SHALL be able to import it.
REQ-026 The iterative mantissa divider SHALL be the sub-module fp16_mant_divider (start, 11-bit dividend/divisor, 14-bit quotient, remainder-nonzero flag, done); unpack, special-case logic and rounding stay in the top level.

Verification
REQ-027 Scenario: a=16'h4600 (6.0), b=16'h4200 (3.0), en pulse -> valid exactly 15 edges later, result=16'h4000.
REQ-028 Scenario: a=16'h3C00, b=16'h4200 (1/3) -> 16'h3555, exercising rounding; a=16'hC600, b=16'h4200 -> 16'hC000.
REQ-029 Scenario: a=16'h3C00, b=16'h0000 -> 16'h7C00; a=16'h0000, b=16'h0000 -> 16'h7E00; a=16'h7C00, b=16'h7C00 -> 16'h7E00; all with 15-cycle latency.
REQ-030 Scenario: a=16'h7BFF, b=16'h3800 -> 16'h7C00 (overflow); a=16'h0400, b=16'h4000 -> 16'h0000 (flush-to-zero).
REQ-031 Scenario: en held high continuously with changing a and b -> only operands sampled in IDLE are used, one valid per 17 cycles, busy never drops mid-operation.
REQ-032 Scenario: reset pulsed at cycle 7 of a division -> valid never asserts, result=16'h0000, busy=0; the next en with 6.0/3.0 -> 16'h4000.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the floating-point arithmetic blocks.
// Holds format constants, the common FSM state type and operand classification.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;
  localparam int BIAS   = 15;
  localparam int QUOT_W = 14;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  // Subnormals (exp == 0) classify as zero.
  function automatic special_t classify_div(input logic [15:0] x, input logic [15:0] y);
    logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    x_zero = (x[14:10] == '0);
    y_zero = (y[14:10] == '0);
    x_inf  = (x[14:10] == '1) && (x[9:0] == '0);
    y_inf  = (y[14:10] == '1) && (y[9:0] == '0);
    x_nan  = (x[14:10] == '1) && (x[9:0] != '0);
    y_nan  = (y[14:10] == '1) && (y[9:0] != '0);
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) return SP_NAN;
    else if (x_inf || y_zero)                                     return SP_INF;
    else if (x_zero || y_inf)                                     return SP_ZERO;
    else                                                          return SP_NONE;
  endfunction

endpackage

// File: rtl/fp16_mant_divider.sv
// Restoring divider for 1.mantissa operands: one quotient bit per cycle, MSB first.
// A start pulse loads the operands; 14 bits follow on the next 14 rising edges.
module fp16_mant_divider
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [MAN_W:0]    i_dividend,
  input  logic [MAN_W:0]    i_divisor,
  output logic [QUOT_W-1:0] o_quot,
  output logic              o_rem_nz,
  output logic              o_done
);

  logic [MAN_W+1:0]  r_rem;
  logic [MAN_W:0]    r_div;
  logic [3:0]        r_cnt;
  logic              r_run;
  logic [QUOT_W-1:0] r_quot;

  logic              w_bit;
  logic [MAN_W+1:0]  w_diff;
  logic [MAN_W+1:0]  w_rem_next;

  // Remainder stays below twice the divisor, so the shifted value fits in 12 bits.
  // NOTE: every always_comb output is assigned on every path so no latch is inferred.
  always_comb begin
    w_diff     = r_rem - {1'b0, r_div};
    w_bit      = (r_rem >= {1'b0, r_div});
    w_rem_next = w_bit ? (w_diff << 1) : (r_rem << 1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the datapath registers are few and small, so they are reset too,
      // which makes abort-and-restart behaviour fully deterministic.
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_quot <= '0;
    end else if (i_start) begin
      r_rem  <= {1'b0, i_dividend};
      r_div  <= i_divisor;
      r_cnt  <= '0;
      r_run  <= 1'b1;
      r_quot <= '0;
    end else if (r_run) begin
      r_rem  <= w_rem_next;
      r_quot <= {r_quot[QUOT_W-2:0], w_bit};
      r_cnt  <= r_cnt + 4'd1;
      if (r_cnt == 4'(QUOT_W - 1)) r_run <= 1'b0;
    end
  end

  assign o_quot   = r_quot;
  assign o_rem_nz = |r_rem;
  assign o_done   = r_run && (r_cnt == 4'(QUOT_W - 1));

endmodule

// File: rtl/floating_point_divider.sv
// IEEE-754 binary16 divider with a fixed 15-edge latency from the accepted start strobe.
// Unpacking, special cases and round-to-nearest-even live here; the mantissa loop is a sub-module.
module floating_point_divider
  import fp16_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  valid,
  output logic                  busy
);

  state_t           r_state;
  logic             r_sign;
  logic [EXP_W-1:0] r_ea;
  logic [EXP_W-1:0] r_eb;
  special_t         r_special;

  logic              w_start;
  logic [QUOT_W-1:0] w_quot;
  logic              w_rem_nz;
  logic              w_div_done;

  logic              w_norm;
  logic [MAN_W:0]    w_mant;
  logic              w_guard;
  logic              w_sticky;
  logic              w_round_up;
  logic [MAN_W+1:0]  w_mant_r;
  logic [MAN_W-1:0]  w_frac;
  logic signed [6:0] w_exp;
  logic [15:0]       w_round_result;

  assign w_start = (r_state == IDLE) && en;

  fp16_mant_divider u_mant_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_dividend ({|a[MAN_W+EXP_W-1:MAN_W], a[MAN_W-1:0]}),
    .i_divisor  ({|b[MAN_W+EXP_W-1:MAN_W], b[MAN_W-1:0]}),
    .o_quot     (w_quot),
    .o_rem_nz   (w_rem_nz),
    .o_done     (w_div_done)
  );

  // Quotient lies in (0.5, 2): a clear integer bit means one normalising shift.
  always_comb begin
    w_norm     = w_quot[QUOT_W-1];
    w_mant     = w_norm ? w_quot[13:3] : w_quot[12:2];
    w_guard    = w_norm ? w_quot[2] : w_quot[1];
    w_sticky   = (w_norm ? (w_quot[1] | w_quot[0]) : w_quot[0]) | w_rem_nz;
    w_round_up = w_guard & (w_sticky | w_mant[0]);
    w_mant_r   = {1'b0, w_mant} + {{MAN_W+1{1'b0}}, w_round_up};
    w_frac     = w_mant_r[MAN_W+1] ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
    w_exp      = 7'(r_ea) - 7'(r_eb) + 7'(BIAS) - {6'd0, ~w_norm}
               + {6'd0, w_mant_r[MAN_W+1]};

    case (r_special)
      SP_NAN:  w_round_result = QNAN;
      SP_INF:  w_round_result = {r_sign, PINF[14:0]};
      SP_ZERO: w_round_result = {r_sign, 15'd0};
      default: begin
        if (w_exp <= 7'sd0)       w_round_result = {r_sign, 15'd0};
        else if (w_exp >= 7'sd31) w_round_result = {r_sign, PINF[14:0]};
        else                      w_round_result = {r_sign, w_exp[EXP_W-1:0], w_frac};
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sign    <= 1'b0;
      r_ea      <= '0;
      r_eb      <= '0;
      r_special <= SP_NONE;
      result    <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_sign    <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
            r_ea      <= a[MAN_W+EXP_W-1:MAN_W];
            r_eb      <= b[MAN_W+EXP_W-1:MAN_W];
            r_special <= classify_div(a[15:0], b[15:0]);
            busy      <= 1'b1;
            r_state   <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (w_div_done) r_state <= ROUND;
        end
        ROUND: begin
          result  <= w_round_result;
          valid   <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floating_point_divider.sv
// Directed bench for floating_point_divider: latency, rounding, special cases,
// held start strobe and mid-operation reset, with hand-computed expected values.
module tb_floating_point_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        valid;
  logic        busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  floating_point_divider #(.DATA_WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .a      (a),
    .b      (b),
    .result (result),
    .valid  (valid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Launches one division and reports the edge count to valid (0 on timeout).
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_in,
                        output int lat, output logic [15:0] res);
    @(negedge clk);
    a  = ta;
    b  = tb_in;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en  = 1'b0;
    a   = 16'hFFFF;
    b   = 16'hFFFF;
    lat = 0;
    res = 16'hxxxx;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = n;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    #12;
    chk_cnt++;
    if ({result, valid, busy} !== {16'h0000, 1'b0, 1'b0})
      $display("FAIL reset_state: result=%h valid=%b busy=%b, expected 0000/0/0", result, valid, busy);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int          lat;
    logic [15:0] res;
    run_op(16'h4600, 16'h4200, lat, res);
    chk_cnt++;
    if (lat !== 15) $display("FAIL basic_latency: got %0d edges, expected 15", lat);
    else pass_cnt++;
    chk_cnt++;
    if (res !== 16'h4000) $display("FAIL basic_result: got %h, expected 4000", res);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy_done: got %b, expected 1", busy);
    else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({valid, busy} !== 2'b00) $display("FAIL basic_after_done: valid/busy=%b%b, expected 00", valid, busy);
    else pass_cnt++;
    repeat (5) @(posedge clk);
    #1;
    chk_cnt++;
    if (result !== 16'h4000) $display("FAIL basic_hold: got %h, expected 4000", result);
    else pass_cnt++;
  endtask

  localparam int NV = 21;
  localparam logic [15:0] VA [NV] = '{
    16'h3C00, 16'hC600, 16'h4500, 16'h3C00, 16'h4000, 16'h7BFF, 16'h0400, 16'hC400,
    16'h3C00, 16'h3C00, 16'h0000, 16'h7C00, 16'h7E01, 16'h3C00, 16'hFC00, 16'h4000,
    16'h8000, 16'hBC00, 16'h0001, 16'h3C00, 16'h0000};
  localparam logic [15:0] VB [NV] = '{
    16'h4200, 16'h4200, 16'h4200, 16'h4700, 16'h4200, 16'h3800, 16'h4000, 16'hC000,
    16'h3C00, 16'h0000, 16'h0000, 16'h7C00, 16'h3C00, 16'h7D00, 16'h4000, 16'h7C00,
    16'h4000, 16'h0000, 16'h3C00, 16'h0200, 16'h4000};
  localparam logic [15:0] VR [NV] = '{
    16'h3555, 16'hC000, 16'h3EAB, 16'h3092, 16'h3955, 16'h7C00, 16'h0000, 16'h4000,
    16'h3C00, 16'h7C00, 16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00, 16'hFC00, 16'h0000,
    16'h8000, 16'hFC00, 16'h0000, 16'h7C00, 16'h0000};

  task automatic test_vectors();
    int          lat;
    logic [15:0] res;
    for (int i = 0; i < NV; i++) begin
      run_op(VA[i], VB[i], lat, res);
      chk_cnt++;
      if (lat !== 15)
        $display("FAIL vec%0d_latency a=%h b=%h: got %0d edges, expected 15", i, VA[i], VB[i], lat);
      else pass_cnt++;
      chk_cnt++;
      if (res !== VR[i])
        $display("FAIL vec%0d_result a=%h b=%h: got %h, expected %h", i, VA[i], VB[i], res, VR[i]);
      else pass_cnt++;
      @(posedge clk);
    end
  endtask

  localparam logic [15:0] HA [3] = '{16'h4600, 16'h3C00, 16'hC600};
  localparam logic [15:0] HB [3] = '{16'h4200, 16'h4200, 16'h4200};
  localparam logic [15:0] HR [3] = '{16'h4000, 16'h3555, 16'hC000};

  task automatic test_en_held();
    logic exp_busy;
    logic exp_valid;
    for (int c = 0; c < 51; c++) begin
      @(negedge clk);
      en = 1'b1;
      if (c % 17 == 0) begin
        a = HA[c / 17];
        b = HB[c / 17];
      end else begin
        a = 16'(c * 16'h0A31);
        b = 16'(16'h7BFF - c * 16'h0111);
      end
      @(posedge clk);
      #1;
      exp_busy  = (c % 17 != 16);
      exp_valid = (c % 17 == 15);
      chk_cnt++;
      if (busy !== exp_busy) $display("FAIL held_busy cyc%0d: got %b, expected %b", c, busy, exp_busy);
      else pass_cnt++;
      chk_cnt++;
      if (valid !== exp_valid) $display("FAIL held_valid cyc%0d: got %b, expected %b", c, valid, exp_valid);
      else pass_cnt++;
      if (exp_valid) begin
        chk_cnt++;
        if (result !== HR[c / 17])
          $display("FAIL held_result op%0d: got %h, expected %h", c / 17, result, HR[c / 17]);
        else pass_cnt++;
      end
    end
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_abort();
    int          lat;
    logic [15:0] res;
    logic        seen;
    @(negedge clk);
    a  = 16'h4600;
    b  = 16'h4200;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_cnt++;
    if ({result, valid, busy} !== {16'h0000, 1'b0, 1'b0})
      $display("FAIL abort_state: result=%h valid=%b busy=%b, expected 0000/0/0", result, valid, busy);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid) seen = 1'b1;
    end
    chk_cnt++;
    if (seen !== 1'b0) $display("FAIL abort_no_valid: valid seen=%b, expected 0", seen);
    else pass_cnt++;
    run_op(16'h4600, 16'h4200, lat, res);
    chk_cnt++;
    if (lat !== 15) $display("FAIL abort_restart_latency: got %0d edges, expected 15", lat);
    else pass_cnt++;
    chk_cnt++;
    if (res !== 16'h4000) $display("FAIL abort_restart_result: got %h, expected 4000", res);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_en_held();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
